// File: rtl/ucore_out_stream_pkg.sv
// Shared constants and pointer helpers for the ucore output stream FIFO.
// Optional overflow flag: define UCORE_OUT_STREAM_OVERFLOW_EN.
package ucore_stream_pkg;

   localparam int unsigned WIDTH_DEF = 32;
   localparam int unsigned DEPTH_DEF = 4;

   // Pointer width: index bits plus one wrap bit separating full from empty.
   function automatic int unsigned ptr_w(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

   typedef logic [ptr_w(DEPTH_DEF)-1:0] ptr_t;

endpackage

// File: rtl/ucore_out_stream_if.sv
// Core write port plus fabric valid/ready stream for ucore_out_stream.
// Optional overflow signals: define UCORE_OUT_STREAM_OVERFLOW_EN.
interface ucore_out_stream_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4
);
   logic                     wr_en;
   logic [WIDTH-1:0]         wr_data;
   logic                     full;
   logic [$clog2(DEPTH):0]   level;
   logic                     out_valid;
   logic [WIDTH-1:0]         out_data;
   logic                     out_ready;
`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
   logic                     ovf_clr;
   logic                     overflow;
`endif

   // Core/fabric side.
   modport master (
      output wr_en, wr_data, out_ready,
`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
      output ovf_clr,
      input  overflow,
`endif
      input  full, level, out_valid, out_data
   );

   // FIFO side.
   modport slave (
      input  wr_en, wr_data, out_ready,
`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
      input  ovf_clr,
      output overflow,
`endif
      output full, level, out_valid, out_data
   );
endinterface

// File: rtl/ucore_out_stream_mem.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, zeroed on reset.
module ucore_stream_mem
   import ucore_stream_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF,
   localparam int unsigned AW   = ptr_w(DEPTH) - 1
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic             we_i,
   input  logic [AW-1:0]    waddr_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic [AW-1:0]    raddr_i,
   output logic [WIDTH-1:0] rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // Storage write; all entries cleared by reset so the head reads zero.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/ucore_out_stream.sv
// First-word-fall-through FIFO from a core output port to a valid/ready stream.
// Optional overflow flag (ovf_clr/overflow): define UCORE_OUT_STREAM_OVERFLOW_EN.
module ucore_out_stream
   import ucore_stream_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF,
   parameter int unsigned DEPTH = DEPTH_DEF
) (
   input logic              clk,
   input logic              aresetn,
   ucore_out_stream_if.slave s
);

   localparam int unsigned PW = ptr_w(DEPTH);
   localparam int unsigned AW = PW - 1;

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic          empty, full, pop, push;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
   assign pop   = !empty && s.out_ready;
   // A pop in the same cycle frees the slot a write into a full FIFO needs.
   assign push  = s.wr_en && (!full || pop);

   // Pointer advance, modulo 2*DEPTH through natural wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   // Pointer registers.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   ucore_stream_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .aresetn (aresetn),
      .we_i    (push),
      .waddr_i (wr_ptr_q[AW-1:0]),
      .wdata_i (s.wr_data),
      .raddr_i (rd_ptr_q[AW-1:0]),
      .rdata_o (s.out_data)
   );

   // Occupancy from registered pointers only; the wrap bit keeps DEPTH distinct from 0.
   assign s.level     = wr_ptr_q - rd_ptr_q;
   assign s.full      = full;
   assign s.out_valid = !empty;

`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
   logic ovf_q;

   // Sticky drop flag; a drop wins over a simultaneous clear.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         ovf_q <= 1'b0;
      end else if (s.wr_en && full && !pop) begin
         ovf_q <= 1'b1;
      end else if (s.ovf_clr) begin
         ovf_q <= 1'b0;
      end
   end

   assign s.overflow = ovf_q;
`endif

endmodule

// File: tb/tb_ucore_out_stream.sv
module tb_ucore_out_stream;
   localparam int unsigned W = 8;
   localparam int unsigned D = 4;

   logic clk = 1'b0;
   logic aresetn = 1'b0;
   always #5 clk = ~clk;

   ucore_out_stream_if #(.WIDTH(W), .DEPTH(D)) bus ();

   ucore_out_stream #(.WIDTH(W), .DEPTH(D)) dut (
      .clk     (clk),
      .aresetn (aresetn),
      .s       (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q [$];
   logic ovf_m = 1'b0;

   // Advance the bench FIFO model by one edge using the current inputs, then step the clock.
   task automatic tick();
      bit pop_m, push_m;
      pop_m  = (exp_q.size() != 0) && bus.out_ready;
      push_m = bus.wr_en && ((exp_q.size() < D) || pop_m);
`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
      if (bus.wr_en && !push_m) ovf_m = 1'b1;
      else if (bus.ovf_clr)     ovf_m = 1'b0;
`endif
      if (pop_m)  void'(exp_q.pop_front());
      if (push_m) exp_q.push_back(bus.wr_data);
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      bus.wr_en = 1'b0; bus.wr_data = '0; bus.out_ready = 1'b0;
`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
      bus.ovf_clr = 1'b0;
`endif
      aresetn = 1'b0;
      exp_q.delete();
      ovf_m = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk); aresetn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      do_reset();
      repeat (2) begin
         checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.out_valid); end
         checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
         checks++; if (bus.level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.level); end
         checks++; if (bus.out_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", bus.out_data); end
         tick();
      end
   endtask

   task automatic test_fill_drop_drain();
      logic [W-1:0] vals [4];
      vals = '{8'h11, 8'h22, 8'h33, 8'h44};
      do_reset();
      foreach (vals[i]) begin
         bus.wr_en = 1'b1; bus.wr_data = vals[i]; bus.out_ready = 1'b0;
         checks++; if (bus.level !== 3'(i)) begin errors++; $display("FAIL fill_level got %0d want %0d", bus.level, i); end
         tick();
      end
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.full); end
      checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL fill_level4 got %0d want 4", bus.level); end
      bus.wr_data = 8'h55;
      tick();
      bus.wr_en = 1'b0;
      checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL drop_level got %0d want 4", bus.level); end
      checks++; if (exp_q.size() != 4 || exp_q[3] !== 8'h44) begin errors++; $display("FAIL drop_model size %0d want 4", exp_q.size()); end
      bus.out_ready = 1'b1;
      repeat (6) begin
         checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL drain_valid got %b want %b", bus.out_valid, exp_q.size() != 0); end
         checks++; if (bus.level !== 3'(exp_q.size())) begin errors++; $display("FAIL drain_level got %0d want %0d", bus.level, exp_q.size()); end
         if (exp_q.size() != 0) begin
            checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL drain_data got %h want %h", bus.out_data, exp_q[0]); end
         end
         tick();
      end
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got %b want 0", bus.out_valid); end
   endtask

   task automatic test_full_passthrough();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = 8'(8'h11 * (i + 1)); bus.out_ready = 1'b0;
         tick();
      end
      // Hold head while stalled
      bus.wr_en = 1'b0;
      tick();
      checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL stall_hold got %h want 11", bus.out_data); end
      bus.wr_en = 1'b1; bus.wr_data = 8'h66; bus.out_ready = 1'b1;
      checks++; if (bus.out_data !== 8'h11) begin errors++; $display("FAIL pass_head got %h want 11", bus.out_data); end
      tick();
      bus.wr_en = 1'b0;
      checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL pass_level got %0d want 4", bus.level); end
      checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL pass_full got %b want 1", bus.full); end
      repeat (5) begin
         checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL pass_valid got %b want %b", bus.out_valid, exp_q.size() != 0); end
         checks++; if (bus.level !== 3'(exp_q.size())) begin errors++; $display("FAIL pass_dlevel got %0d want %0d", bus.level, exp_q.size()); end
         if (exp_q.size() != 0) begin
            checks++; if (bus.out_data !== exp_q[0]) begin errors++; $display("FAIL pass_data got %h want %h", bus.out_data, exp_q[0]); end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         bus.wr_en   = (i < 10);
         bus.wr_data = 8'(i);
         checks++; if (bus.level > 3'd1 || bus.level !== 3'(exp_q.size())) begin errors++; $display("FAIL b2b_level got %0d want %0d", bus.level, exp_q.size()); end
         checks++; if (bus.out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL b2b_valid got %b want %b", bus.out_valid, exp_q.size() != 0); end
         if (exp_q.size() != 0) begin
            checks++; if (bus.out_data !== exp_q[0] || exp_q[0] !== 8'(i - 1)) begin errors++; $display("FAIL b2b_data got %h want %h", bus.out_data, exp_q[0]); end
         end
         tick();
      end
      bus.wr_en = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %b want 0", bus.out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.wr_en = 1'b1; bus.wr_data = 8'hA5; bus.out_ready = 1'b0;
      tick();
      bus.wr_en = 1'b0;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_data !== 8'hA5) begin errors++; $display("FAIL mid_pre got %b/%h want 1/a5", bus.out_valid, bus.out_data); end
      #2 aresetn = 1'b0;
      #1;
      exp_q.delete(); ovf_m = 1'b0;
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_async got %b want 0", bus.out_valid); end
      @(negedge clk); aresetn = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         checks++; if (bus.out_valid !== 1'b0 || bus.level !== 3'd0) begin errors++; $display("FAIL mid_after got %b/%0d want 0/0", bus.out_valid, bus.level); end
         tick();
      end
   endtask

`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.wr_en = 1'b1; bus.wr_data = 8'(i); bus.out_ready = 1'b0;
         tick();
      end
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_idle got %b want 0", bus.overflow); end
      tick();
      bus.wr_en = 1'b0;
      checks++; if (bus.overflow !== 1'b1 || ovf_m !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", bus.overflow); end
      bus.ovf_clr = 1'b1;
      tick();
      bus.ovf_clr = 1'b0;
      checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", bus.overflow); end
      bus.ovf_clr = 1'b1; bus.wr_en = 1'b1;
      tick();
      bus.ovf_clr = 1'b0; bus.wr_en = 1'b0;
      checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_setwins got %b want 1", bus.overflow); end
      checks++; if (bus.level !== 3'd4) begin errors++; $display("FAIL ovf_level got %0d want 4", bus.level); end
   endtask
`endif

   initial begin
      test_reset();
      test_fill_drop_drain();
      test_full_passthrough();
      test_back_to_back();
      test_reset_mid();
`ifdef UCORE_OUT_STREAM_OVERFLOW_EN
      test_overflow();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
